// File: rtl/data_mem_sized_if.sv
// Request/response bundle between the MEM stage (master) and the sized data memory (slave).
interface data_mem_sized_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_sized.sv
// Byte-addressed little-endian RV64I data memory over a 64-bit word array.
// Sized loads/stores; word-crossing accesses take a second beat through the SPLIT state.
module data_mem_sized #(
  parameter int ADDR_W      = 16,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  data_mem_sized_if.slave  bus
);

  localparam int WORDS = 2 ** (ADDR_W - 3);
  localparam int IDX_W = ADDR_W - 3;

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] extend_load(input logic [63:0] raw, input logic [1:0] size,
                                              input logic uns);
    case (size)
      2'b00:   extend_load = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
      2'b01:   extend_load = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10:   extend_load = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: extend_load = raw;
    endcase
  endfunction

  logic [63:0]      mem [WORDS];

  state_t           state_r;
  logic             ready_r;
  logic             rsp_valid_r;
  logic             rsp_err_r;
  logic [63:0]      rsp_rdata_r;

  logic             we_r;
  logic             uns_r;
  logic [1:0]       size_r;
  logic [2:0]       off_r;
  logic [IDX_W-1:0] hi_idx_r;
  logic [7:0]       hi_be_r;
  logic [63:0]      hi_wd_r;
  logic [63:0]      lo_word_r;

  logic             accept_s;
  logic [2:0]       off_s;
  logic [5:0]       sh_s;
  logic [3:0]       nbytes_s;
  logic [32:0]      end_addr_s;
  logic             range_err_s;
  logic             cross_s;
  logic             err_s;
  logic [IDX_W-1:0] idx_s;
  logic [15:0]      be_s;
  logic [63:0]      wd_lo_s;
  logic [63:0]      wd_hi_s;
  logic [63:0]      lo_word_s;
  logic [63:0]      single_raw_s;
  logic [63:0]      split_raw_s;

  logic             wr_en_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [7:0]       wr_be_s;
  logic [63:0]      wr_data_s;

  // Request decode: span, range/crossing checks, and byte-lane alignment of data and enables.
  always_comb begin
    accept_s     = bus.req_valid & ready_r & (state_r == IDLE);
    off_s        = bus.req_addr[2:0];
    sh_s         = {off_s, 3'b000};
    nbytes_s     = 4'd1 << bus.req_size;
    end_addr_s   = {1'b0, bus.req_addr} + {29'd0, nbytes_s} - 33'd1;
    range_err_s  = |end_addr_s[32:ADDR_W];
    cross_s      = ({1'b0, off_s} + nbytes_s) > 4'd8;
    err_s        = range_err_s | (cross_s & ~MISALIGN_EN);
    idx_s        = bus.req_addr[ADDR_W-1:3];
    be_s         = {8'h00, size_mask(bus.req_size)} << off_s;
    wd_lo_s      = bus.req_wdata << sh_s;
    wd_hi_s      = bus.req_wdata >> (7'd64 - {1'b0, sh_s});
    lo_word_s    = mem[idx_s];
    single_raw_s = lo_word_s >> sh_s;
    // off_r is never 0 in SPLIT, so the high-word shift stays below 64
    split_raw_s  = (lo_word_r >> {off_r, 3'b000})
                 | (mem[hi_idx_r] << (7'd64 - {1'b0, off_r, 3'b000}));
  end

  // Single write port: beat 1 / single-word store in IDLE, beat 2 store in SPLIT.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = idx_s;
    wr_be_s   = 8'h00;
    wr_data_s = 64'd0;
    if (accept_s && bus.req_we && !err_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = idx_s;
      wr_be_s   = be_s[7:0];
      wr_data_s = wd_lo_s;
    end else if ((state_r == SPLIT) && we_r) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = hi_idx_r;
      wr_be_s   = hi_be_r;
      wr_data_s = hi_wd_r;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Word array with per-byte enables; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_be_s[b]) begin
          mem[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered response and ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 64'd0;
      we_r        <= 1'b0;
      uns_r       <= 1'b0;
      size_r      <= 2'b00;
      off_r       <= 3'd0;
      hi_idx_r    <= '0;
      hi_be_r     <= 8'h00;
      hi_wd_r     <= 64'd0;
      lo_word_r   <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (err_s) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= 64'd0;
            end else if (cross_s) begin
              state_r     <= SPLIT;
              ready_r     <= 1'b0;
              rsp_valid_r <= 1'b0;
              rsp_err_r   <= 1'b0;
              rsp_rdata_r <= 64'd0;
              we_r        <= bus.req_we;
              uns_r       <= bus.req_unsigned;
              size_r      <= bus.req_size;
              off_r       <= off_s;
              hi_idx_r    <= idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
              hi_be_r     <= be_s[15:8];
              hi_wd_r     <= wd_hi_s;
              lo_word_r   <= lo_word_s;
            end else begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b0;
              rsp_rdata_r <= bus.req_we ? 64'd0
                                        : extend_load(single_raw_s, bus.req_size, bus.req_unsigned);
            end
          end else begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 64'd0;
          end
        end
        SPLIT: begin
          state_r     <= IDLE;
          ready_r     <= 1'b1;
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= we_r ? 64'd0 : extend_load(split_raw_s, size_r, uns_r);
        end
        default: begin
          state_r     <= IDLE;
          ready_r     <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= 64'd0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_r & rst_n;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_data_mem_sized.sv
// Self-checking bench for data_mem_sized: byte-array reference model, expected-response queue,
// directed cases from the datasheet scenarios plus randomized sized accesses.
module tb_data_mem_sized;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_sized_if bus ();
  data_mem_sized_if bus0 ();

  data_mem_sized #(.ADDR_W(16), .MISALIGN_EN(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  data_mem_sized #(.ADDR_W(16), .MISALIGN_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  typedef struct {
    int          due;
    logic        err;
    logic [63:0] rdata;
    bit          has_spec;
    logic [63:0] spec;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  mref [0:65535];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: a flat byte array, spans computed from the address arithmetic directly.
  task automatic model_access(input bit we, input int addr, input int size, input bit uns,
                              input logic [63:0] wd, output bit err, output logic [63:0] rd,
                              output bit split);
    int n;
    longint last;
    n = 1 << size;
    last = longint'(addr) + n - 1;
    split = (longint'(addr) / 8) != (last / 8);
    err = (last >= 65536);
    rd = 64'd0;
    if (err) begin
      split = 1'b0;
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (we) mref[addr + k] = wd[8*k +: 8];
      else    rd[8*k +: 8] = mref[addr + k];
    end
    if (!we && !uns && n < 8 && rd[8*n-1]) rd = rd | (~64'd0 << (8*n));
  endtask

  task automatic issue(input bit we, input int addr, input int size, input bit uns,
                       input logic [63:0] wd, input bit has_spec = 1'b0,
                       input logic [63:0] spec = 64'd0);
    int waited;
    exp_t e;
    bit err;
    bit split;
    logic [63:0] rd;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = 32'(addr);
    bus.req_size     = 2'(size);
    bus.req_unsigned = uns;
    bus.req_wdata    = wd;
    waited = 0;
    while (!bus.req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check_val("ready_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    model_access(we, addr, size, uns, wd, err, rd, split);
    e.due      = cyc + 1 + (split ? 1 : 0);
    e.err      = err;
    e.rdata    = rd;
    e.has_spec = has_spec;
    e.spec     = spec;
    expq.push_back(e);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 20) begin
      idle_cycle();
      n++;
    end
    if (expq.size() > 0) check_val("drain_timeout", 64'(expq.size()), 64'd0);
  endtask

  task automatic issue0(input bit we, input int addr, input int size, input logic [63:0] wd,
                        output logic v, output logic er, output logic [63:0] rd);
    @(negedge clk);
    bus0.req_valid    = 1'b1;
    bus0.req_we       = we;
    bus0.req_addr     = 32'(addr);
    bus0.req_size     = 2'(size);
    bus0.req_unsigned = 1'b0;
    bus0.req_wdata    = wd;
    check_val("t4_ready", 64'(bus0.req_ready), 64'd1);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    v  = bus0.rsp_valid;
    er = bus0.rsp_err;
    rd = bus0.rsp_rdata;
  endtask

  // Response monitor: every response must match the queue head in cycle, error and data.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid) begin
      if (expq.size() == 0) begin
        check_val("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = expq.pop_front();
        check_val("rsp_cycle", 64'(cyc), 64'(e.due));
        check_val("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        check_val("rsp_rdata", bus.rsp_rdata, e.rdata);
        if (e.has_spec) check_val("spec_rdata", bus.rsp_rdata, e.spec);
      end
    end else if (expq.size() > 0 && expq[0].due <= cyc) begin
      check_val("rsp_missing", 64'd0, 64'd1);
      void'(expq.pop_front());
    end
  end

  initial begin
    logic v;
    logic er;
    logic [63:0] rd;
    logic [63:0] wsplit;
    int addr;
    int size;

    bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_addr = 32'd0;
    bus.req_size = 2'd0;   bus.req_unsigned = 1'b0;  bus.req_wdata = 64'd0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'd0;
    bus0.req_size = 2'd0;  bus0.req_unsigned = 1'b0; bus0.req_wdata = 64'd0;

    repeat (3) @(negedge clk);
    check_val("rst_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("rst_rdata", bus.rsp_rdata, 64'd0);
    check_val("rst_err", 64'(bus.rsp_err), 64'd0);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_ready", 64'(bus.req_ready), 64'd1);

    // MISALIGN_EN=0 instance: crossing store is rejected with latency 1 and writes nothing
    issue0(1'b1, 'h108, 3, 64'h0123456789ABCDEF, v, er, rd);
    check_val("t4_sd_valid", 64'(v), 64'd1);
    issue0(1'b1, 'h10F, 1, 64'h1234, v, er, rd);
    check_val("t4_sh_valid", 64'(v), 64'd1);
    check_val("t4_sh_err", 64'(er), 64'd1);
    check_val("t4_sh_rdata", rd, 64'd0);
    issue0(1'b0, 'h108, 3, 64'd0, v, er, rd);
    check_val("t4_ld_err", 64'(er), 64'd0);
    check_val("t4_ld_rdata", rd, 64'h0123456789ABCDEF);

    for (int w = 0; w < 64; w++) issue(1'b1, w * 8, 3, 1'b0, {$urandom, $urandom});
    for (int w = 0; w < 8; w++)  issue(1'b1, 'hFFC0 + w * 8, 3, 1'b0, {$urandom, $urandom});

    issue(1'b1, 'h103, 0, 1'b0, 64'h80);
    issue(1'b0, 'h103, 0, 1'b0, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFF80);
    issue(1'b0, 'h103, 0, 1'b1, 64'd0, 1'b1, 64'h0000000000000080);
    issue(1'b1, 'h100, 3, 1'b0, 64'h1122334455667788);
    issue(1'b0, 'h100, 3, 1'b0, 64'd0, 1'b1, 64'h1122334455667788);

    issue(1'b1, 'h106, 2, 1'b0, 64'hDEADBEEF);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_val("t3_ready_low", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check_val("t3_ready_back", 64'(bus.req_ready), 64'd1);
    issue(1'b0, 'h100, 3, 1'b0, 64'd0, 1'b1, 64'hBEEF334455667788);
    issue(1'b0, 'h106, 2, 1'b0, 64'd0, 1'b1, 64'hFFFFFFFFDEADBEEF);
    issue(1'b0, 'h108, 1, 1'b1, 64'd0, 1'b1, 64'h000000000000DEAD);

    issue(1'b0, 'h10000, 3, 1'b0, 64'd0, 1'b1, 64'd0);
    issue(1'b1, 'hFFFC, 3, 1'b0, 64'hCAFEF00DCAFEF00D);
    issue(1'b0, 'hFFF8, 3, 1'b0, 64'd0);
    issue(1'b0, 'hFFFF, 0, 1'b0, 64'd0);

    for (int i = 0; i < 8; i++) issue(1'b0, i * 8, 3, 1'b0, 64'd0);
    drain();

    // Reset while the second beat of a split store is pending
    wsplit = 64'hA1A2A3A4A5A6A7A8;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h1C4;
    bus.req_size = 2'd3;  bus.req_wdata = wsplit;
    check_val("t6_split_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    check_val("t6_split_ready_low", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("t6_rst_ready", 64'(bus.req_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("t6_release_ready", 64'(bus.req_ready), 64'd1);
    for (int k = 0; k < 4; k++) mref['h1C4 + k] = wsplit[8*k +: 8];
    issue(1'b0, 'h1C0, 3, 1'b0, 64'd0);
    issue(1'b0, 'h1C8, 3, 1'b0, 64'd0);

    for (int i = 0; i < 400; i++) begin
      size = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) addr = 'hFFC0 + int'($urandom_range(0, 71));
      else                           addr = int'($urandom_range(0, 'h1F8));
      issue($urandom_range(0, 1) == 1, addr, size, $urandom_range(0, 1) == 1, {$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
